// File: rtl/nnue_if.sv
// rtl/nnue_if.sv - request/result handshake between search core and NNUE evaluator
interface nnue_if;
  logic               trigger;
  logic               player;
  logic [6:0]         row;
  logic               add;
  logic               finish;
  logic signed [15:0] out;

  modport master (output trigger, player, row, add, input finish, out);
  modport slave  (input trigger, player, row, add, output finish, out);
endinterface

// File: rtl/nnue.sv
// rtl/nnue.sv - incremental two-accumulator NNUE evaluator
// One lane update per cycle, then a serial clipped-ReLU MAC over both accumulators.
module nnue #(
  parameter int H    = 16,
  parameter int ROWS = 128,
  parameter int WW   = 8,
  parameter int AW   = 16
) (
  input  logic clk,
  input  logic rst_n,
  nnue_if.slave bus
);
  localparam int HW = $clog2(H);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(2 * H + 2);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_EVAL, S_DONE} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_player;
  logic                  r_add;
  logic [RW-1:0]         r_row;
  logic signed [AW-1:0]  r_acc [2][H];
  logic signed [31:0]    r_mac;
  logic signed [31:0]    r_prod;
  logic                  r_finish;
  logic signed [15:0]    r_out;

  logic [HW-1:0]         w_lane;
  logic [3:0]            w_mod;
  logic signed [WW-1:0]  w_ft;
  logic signed [AW-1:0]  w_cur;
  logic signed [AW:0]    w_sum;
  logic signed [AW-1:0]  w_sat;
  logic                  w_self;
  logic                  w_sel;
  logic signed [AW-1:0]  w_x;
  logic [7:0]            w_cr;
  logic signed [WW-1:0]  w_wself;
  logic signed [WW-1:0]  w_wt;
  logic signed [31:0]    w_prod;
  logic signed [15:0]    w_mac_sat;

  always_comb begin
    w_lane  = r_cnt[HW-1:0];
    w_mod   = 4'(r_row + RW'(w_lane));
    w_ft    = $signed({{(WW-4){1'b0}}, w_mod}) - WW'(8);
    w_cur   = r_acc[r_player][w_lane];
    w_sum   = r_add ? ((AW+1)'(w_cur) + (AW+1)'(w_ft)) : ((AW+1)'(w_cur) - (AW+1)'(w_ft));
    // Overflow shows as the two top bits of the widened sum disagreeing.
    if (w_sum[AW] != w_sum[AW-1])
      w_sat = w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else
      w_sat = w_sum[AW-1:0];

    w_self  = (r_cnt < CW'(H));
    w_sel   = w_self ? r_player : ~r_player;
    w_x     = r_acc[w_sel][w_lane];
    if (w_x[AW-1])
      w_cr = 8'd0;
    else if (|w_x[AW-2:7])
      w_cr = 8'd127;
    else
      w_cr = {1'b0, w_x[6:0]};
    w_wself = WW'(w_lane) - WW'(8);
    w_wt    = w_self ? w_wself : -w_wself;
    w_prod  = 32'($signed({1'b0, w_cr})) * 32'(w_wt);

    if (r_mac > 32'sd32767)
      w_mac_sat = 16'sh7fff;
    else if (r_mac < -32'sd32768)
      w_mac_sat = 16'sh8000;
    else
      w_mac_sat = r_mac[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_player <= 1'b0;
      r_add    <= 1'b0;
      r_row    <= '0;
      r_mac    <= '0;
      r_prod   <= '0;
      r_finish <= 1'b0;
      r_out    <= '0;
      for (int p = 0; p < 2; p++)
        for (int j = 0; j < H; j++)
          r_acc[p][j] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.trigger) begin
            r_player <= bus.player;
            r_row    <= bus.row[RW-1:0];
            r_add    <= bus.add;
            r_cnt    <= '0;
            r_state  <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_acc[r_player][w_lane] <= w_sat;
          if (r_cnt == CW'(H - 1)) begin
            r_cnt   <= '0;
            r_mac   <= '0;
            r_prod  <= '0;
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EVAL: begin
          // Product is registered, so two drain cycles follow the last term.
          r_mac  <= r_mac + r_prod;
          r_prod <= (r_cnt < CW'(2 * H)) ? w_prod : 32'sd0;
          if (r_cnt == CW'(2 * H + 1)) begin
            r_out    <= w_mac_sat;
            r_finish <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_finish <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.finish = r_finish;
  assign bus.out    = r_out;
endmodule

// File: tb/tb_nnue.sv
// tb/tb_nnue.sv - directed checks of NNUE evaluator latency, arithmetic and saturation
module tb_nnue;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  int   first_c;
  int   pulses;
  int   n_fin;

  nnue_if bus ();

  nnue u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Starts one op at the next edge and watches 60 cycles for finish pulses.
  task automatic run_op(input logic p, input logic [6:0] r, input logic a, input logic glitch);
    bus.trigger = 1'b1;
    bus.player  = p;
    bus.row     = r;
    bus.add     = a;
    @(posedge clk);
    #1 bus.trigger = 1'b0;
    bus.player = ~p;
    bus.add    = ~a;
    first_c = -1;
    pulses  = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.finish) begin
        pulses++;
        if (first_c < 0) first_c = c;
      end
      if (glitch && c == 10) bus.trigger = 1'b1;
      if (c == 11) bus.trigger = 1'b0;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    bus.trigger = 1'b0;
    bus.player  = 1'b0;
    bus.row     = '0;
    bus.add     = 1'b0;
    do_reset();
    check("reset_out", int'(bus.out), 0);
    check("reset_finish", int'(bus.finish), 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (bus.finish) pulses++;
    end
    check("idle_no_finish", pulses, 0);

    run_op(1'b1, 7'd0, 1'b1, 1'b0);
    check("op1_latency", first_c, 50);
    check("op1_pulses", pulses, 1);
    check("op1_out", int'(bus.out), 140);
    repeat (5) @(posedge clk);
    #1 check("op1_hold", int'(bus.out), 140);

    run_op(1'b1, 7'd0, 1'b1, 1'b0);
    check("op2_out", int'(bus.out), 280);
    run_op(1'b1, 7'd0, 1'b0, 1'b0);
    check("op3_sub_out", int'(bus.out), 140);

    do_reset();
    run_op(1'b1, 7'd0, 1'b1, 1'b0);
    check("op4_out", int'(bus.out), 140);
    run_op(1'b0, 7'd0, 1'b0, 1'b0);
    check("p0_latency", first_c, 50);
    check("p0_out", int'(bus.out), -344);

    run_op(1'b1, 7'd0, 1'b0, 1'b1);
    check("glitch_pulses", pulses, 1);
    check("glitch_latency", first_c, 50);
    check("glitch_out", int'(bus.out), 204);

    do_reset();
    bus.trigger = 1'b1;
    bus.player  = 1'b1;
    bus.row     = 7'd0;
    bus.add     = 1'b1;
    n_fin = 0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #1;
      if (bus.finish) n_fin++;
      if (n_fin == 300) break;
    end
    bus.trigger = 1'b0;
    check("sat_finishes", n_fin, 300);
    check("sat_out", int'(bus.out), 3556);
    repeat (60) @(posedge clk);
    #1 check("sat_stopped", int'(bus.finish), 0);

    bus.trigger = 1'b1;
    @(posedge clk);
    #1 bus.trigger = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_finish", int'(bus.finish), 0);
    check("midrst_out", int'(bus.out), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (60) begin
      @(posedge clk);
      #1 if (bus.finish) pulses++;
    end
    check("midrst_no_finish", pulses, 0);
    run_op(1'b1, 7'd0, 1'b1, 1'b0);
    check("post_rst_out", int'(bus.out), 140);
    check("post_rst_pulses", pulses, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
